// File: rtl/tone_detector.sv
// Receive-side tone detector: measures the rising-edge period of a 1-bit audio line
// and classifies it as the shot tone, the collision tone, or neither.
module tone_detector #(
  parameter int PERIOD_W    = 22,
  parameter int SHOT_PERIOD = 131072,
  parameter int COLL_PERIOD = 1048576,
  parameter int TOL         = 4096,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT     = 2097152
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pin_in,
  output logic                shot_det,
  output logic                collision_det,
  output logic                det_event,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int CW = (PERIOD_W > 32) ? PERIOD_W : 32;
  localparam logic [2:0] CONF = 3'(CONFIRM);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_e;
  typedef enum logic [1:0] {CLS_NONE, CLS_SHOT, CLS_COLL} cls_e;

  state_e              state_q, state_d;
  cls_e                last_class, cls_now, cls_d;
  logic [2:0]          match_cnt, mc_d;
  logic [PERIOD_W-1:0] cnt;
  logic                pin_p0, pin_p1, pin_p2;
  logic                rise, at_timeout, capture, timeout;
  logic                shot_q, coll_q;

  function automatic cls_e classify(input logic [PERIOD_W-1:0] p);
    logic [CW-1:0] pw;
    pw = CW'(p);
    if (pw >= CW'(SHOT_PERIOD - TOL) && pw <= CW'(SHOT_PERIOD + TOL))
      return CLS_SHOT;
    if (pw >= CW'(COLL_PERIOD - TOL) && pw <= CW'(COLL_PERIOD + TOL))
      return CLS_COLL;
    return CLS_NONE;
  endfunction

  assign rise       = pin_p1 & ~pin_p2;
  assign at_timeout = (CW'(cnt) == CW'(TIMEOUT));
  assign capture    = rise && (state_q != IDLE);
  // A rise on the threshold cycle wins over the timeout.
  assign timeout    = !rise && at_timeout && (state_q != IDLE);
  assign cls_now    = classify(cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = ARMED;
      ARMED:   if (rise) state_d = TRACK; else if (timeout) state_d = IDLE;
      TRACK:   if (timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cls_d = last_class;
    mc_d  = match_cnt;
    if (timeout) begin
      cls_d = CLS_NONE;
      mc_d  = 3'd0;
    end else if (capture) begin
      cls_d = cls_now;
      if (cls_now == CLS_NONE)        mc_d = 3'd0;
      else if (cls_now == last_class) mc_d = (match_cnt >= CONF) ? CONF : match_cnt + 3'd1;
      else                            mc_d = 3'd1;
    end
  end

  // _p0/_p1 synchronize the async line, _p2 is the edge-detect history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_p0 <= 1'b0;
      pin_p1 <= 1'b0;
      pin_p2 <= 1'b0;
    end else begin
      pin_p0 <= pin_in;
      pin_p1 <= pin_p0;
      pin_p2 <= pin_p1;
    end
  end

  // Period measurement, classification and detect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      period        <= '0;
      period_valid  <= 1'b0;
      match_cnt     <= 3'd0;
      last_class    <= CLS_NONE;
      shot_det      <= 1'b0;
      collision_det <= 1'b0;
      shot_q        <= 1'b0;
      coll_q        <= 1'b0;
      det_event     <= 1'b0;
    end else begin
      if (state_q == IDLE)  cnt <= rise ? PERIOD_W'(1) : '0;
      else if (rise)        cnt <= PERIOD_W'(1);
      else if (timeout)     cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + PERIOD_W'(1);
      period_valid  <= capture;
      if (capture) period <= cnt;
      match_cnt     <= mc_d;
      last_class    <= cls_d;
      shot_det      <= (mc_d == CONF) && (cls_d == CLS_SHOT);
      collision_det <= (mc_d == CONF) && (cls_d == CLS_COLL);
      shot_q        <= shot_det;
      coll_q        <= collision_det;
      det_event     <= (shot_det & ~shot_q) | (collision_det & ~coll_q);
    end
  end

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive-side counterpart of the game's 1-bit square-wave speaker driver.
- Samples a 1-bit audio line, measures the period between rising edges, and classifies it as the shot tone, the collision tone, or neither.
- Drives level and pulse outputs for the on-board self-test / loopback path and for simulation benches checking sound generation.

Parameters:
- PERIOD_W, 22, width of the period counter and of the period output.
- SHOT_PERIOD, 131072, nominal shot-tone period in clocks.
- COLL_PERIOD, 1048576, nominal collision-tone period in clocks.
- TOL, 4096, allowed ± deviation in clocks; inclusive bounds.
- CONFIRM, 3, consecutive same-class periods needed before a detect asserts (1..7).
- TIMEOUT, 2097152, clocks without a rising edge before tracking is abandoned.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- pin_in  input  1  asynchronous 1-bit audio line.
- shot_det  output  1  level, shot tone confirmed and present.
- collision_det  output  1  level, collision tone confirmed and present.
- det_event  output  1  one-cycle pulse when either detect goes 0->1.
- period  output  PERIOD_W  last measured period in clocks.
- period_valid  output  1  one-cycle pulse when period updates.

Behaviour:
- Reset: one clock; rst is asynchronous, active-low. While rst=0 all outputs and state are 0, synchronizer is cleared, and the FSM is in IDLE. Reset asserted mid-tone clears everything immediately, with no completion pulse.
- Input conditioning: pin_in passes through a 2-flop synchronizer, then a third flop for edge detect. Rising edge "rise" = sync2 & ~sync3. Latency from a pin_in rising edge to rise is 3 clk edges.
- Period counter: set to 1 on rise, otherwise increments by 1 and saturates at all-ones. A square wave toggling every 2^16 clocks yields period = 131072 exactly.
- FSM states:
  - IDLE: counter held at 0. On rise, go to ARMED and set counter to 1. No period output.
  - ARMED: waiting for the second edge. On rise, capture counter into period, pulse period_valid, go to TRACK.
  - TRACK: on every rise, capture, pulse period_valid, and classify.
  - Any state except IDLE: counter reaching TIMEOUT with no rise returns to IDLE. This clears shot_det, collision_det, and match_cnt; period holds its last value.
- Classification of captured p, evaluated on the period_valid cycle:
  - SHOT if SHOT_PERIOD-TOL <= p <= SHOT_PERIOD+TOL.
  - COLL if COLL_PERIOD-TOL <= p <= COLL_PERIOD+TOL.
  - Else NONE. Windows must not overlap (parameter constraint, not checked).
- Match counting, on each period_valid:
  - Class equals last_class and is not NONE: match_cnt = min(match_cnt+1, CONFIRM).
  - Class is not NONE but differs: match_cnt = 1.
  - Class is NONE: match_cnt = 0.
  - last_class <= class.
- Detect outputs, registered and updated the same edge as match_cnt:
  - shot_det = (match_cnt==CONFIRM && last_class==SHOT).
  - collision_det likewise for COLL.
  - Never both 1.
  - A non-matching or NONE period drops the active detect on that edge.
  - A class switch drops the old detect immediately; the new one asserts after CONFIRM periods of the new class.
- det_event: 1 for exactly one cycle, the cycle after either detect rises. It does not repeat while the detect is held.
- Simultaneous rise and timeout threshold on the same cycle: rise wins, counter restarts, no timeout.
- Counter saturation below TIMEOUT (TIMEOUT > 2^PERIOD_W-1): saturated value is captured and classifies as NONE.
- Glitches shorter than 2 clocks may be missed; no debounce beyond the synchronizer.

Test Plan:
- Square wave, half-period 65536 clocks, 5 rising edges -> period_valid on edges 2..5 with period=131072. shot_det rises at edge 4 (3rd period), det_event single pulse, collision_det stays 0.
- Half-period 524288, 4 edges -> period=1048576. collision_det asserts on 3rd period, one det_event, shot_det 0.
- Shot tone confirmed, then the line is held low -> both detects 0 exactly TIMEOUT clocks after the last rise, FSM IDLE, period unchanged at 131072, no period_valid.
- Shot tone confirmed, then switch to half-period 524288 -> shot_det drops on the first 1048576 capture, collision_det asserts on the 3rd collision period.
- Boundary periods 131072±4096 accepted and ±4097 rejected, 3 periods each -> shot_det=1 for the accepted cases, 0 for the rejected ones with match_cnt 0.
- rst pulsed low mid-collision tone -> all outputs 0 asynchronously. After release, first rise -> ARMED only, no period_valid until the second rise.
